dmem_arbiter: RTL and testbench

- Shares the single-port word-addressed data memory between two masters: the CPU load/store port (m0) and a debug/program-loader port (m1).
- Uses round-robin arbitration with a bounded burst-hold: the current owner keeps the memory for up to MAX_BURST consecutive transfers while it keeps requesting, then priority rotates.
- Memory write is synchronous; memory read is synchronous with 1-cycle latency. Read data returns to the master that issued the read.

---
 rtl/dmem_arb_pkg.sv | 28 ++
 rtl/dmem_arb_if.sv | 59 +++++
 rtl/dmem_arb_pick.sv | 87 ++++++++
 rtl/dmem_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the two-master data-memory arbiter.
//   arb_state_t   : arbiter state (ARB_IDLE / ARB_OWN0 / ARB_OWN1)
//   M_CPU / M_DBG : master index values used for the last-owner pointer
//                   and the read-return tag
//   CNT_W         : width of the burst beat counter
//   cnt_sat_inc   : saturating increment of the beat counter
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c,
                                                     input logic [CNT_W-1:0] lim);
        return (c >= lim) ? lim : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// ---------------------------------------------------------------------------
// dmem_arb_if
// Bundle of the two master handshake ports and the memory-side port of the
// data-memory arbiter.
//   m0_* : CPU load/store port       (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   m1_* : debug / program-loader port (same shape as m0_*)
//   mem_*: single-port memory strobe/address/data, mem_rdata returned 1 cycle
//          after a read strobe
//   busy : arbiter holds an owner or has a read in flight
// Modports: slave = arbiter side, master = environment (masters + memory).
// ---------------------------------------------------------------------------
interface dmem_arb_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/dmem_arb_pick.sv
// ---------------------------------------------------------------------------
// dmem_arb_pick
// Combinational winner select for the data-memory arbiter.
// Config macro: DMEM_ARB_FIXED_PRIO_EN
//   undefined : round-robin with burst-hold (owner keeps the memory for up to
//               MAX_BURST beats while the other master waits)
//   defined   : m0 always wins; m1 only when m0 is not requesting
// Ports:
//   i_req0/i_req1 : master requests
//   i_state/i_cnt/i_last : registered arbiter state, beat count, last owner
//   o_gnt0/o_gnt1 : grants (at most one high)
//   o_nxt_state/o_nxt_cnt/o_nxt_last : next registered values
// ---------------------------------------------------------------------------
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic             i_req0,
    input  logic             i_req1,
    input  arb_state_t       i_state,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_last,
    output logic             o_gnt0,
    output logic             o_gnt1,
    output arb_state_t       o_nxt_state,
    output logic [CNT_W-1:0] o_nxt_cnt,
    output logic             o_nxt_last
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_BURST);

    logic w_any;
    logic w_pick1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic w_owner;
    logic w_req_own;
    logic w_req_oth;
`endif

    always_comb begin
        w_any       = 1'b0;
        w_pick1     = 1'b0;
        o_gnt0      = 1'b0;
        o_gnt1      = 1'b0;
        o_nxt_state = i_state;
        o_nxt_cnt   = i_cnt;
        o_nxt_last  = i_last;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        w_any   = i_req0 | i_req1;
        w_pick1 = ~i_req0;
`else
        w_owner   = (i_state == ARB_OWN1);
        w_req_own = w_owner ? i_req1 : i_req0;
        w_req_oth = w_owner ? i_req0 : i_req1;
        case (i_state)
            ARB_OWN0, ARB_OWN1: begin
                w_any = w_req_own | w_req_oth;
                // Owner keeps the bus unless it stopped asking or has used
                // up its burst while the other master waits.
                if (w_req_own && !(w_req_oth && (i_cnt >= LIM)))
                    w_pick1 = w_owner;
                else
                    w_pick1 = ~w_owner;
            end
            default: begin
                w_any   = i_req0 | i_req1;
                // On contention the master that did not own last wins.
                w_pick1 = i_req1 & (~i_req0 | (i_last == M_CPU));
            end
        endcase
`endif
        if (w_any) begin
            o_gnt0      = ~w_pick1;
            o_gnt1      = w_pick1;
            o_nxt_state = w_pick1 ? ARB_OWN1 : ARB_OWN0;
            o_nxt_last  = w_pick1;
            if (i_state == (w_pick1 ? ARB_OWN1 : ARB_OWN0))
                o_nxt_cnt = cnt_sat_inc(i_cnt, LIM);
            else
                o_nxt_cnt = CNT_W'(1);
        end else begin
            o_nxt_state = ARB_IDLE;
            o_nxt_cnt   = '0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port, word-addressed data memory between the CPU port (m0)
// and a debug/program-loader port (m1). Grants are combinational from the
// current requests and registered state; mem_* follow the granted master.
// Reads have one cycle of latency and are returned to the issuing master.
// Config macro: DMEM_ARB_FIXED_PRIO_EN (fixed m0 priority instead of
// round-robin with burst-hold; handled inside dmem_arb_pick).
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : dmem_arb_if.slave (m0_*, m1_*, mem_*, busy)
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    dmem_arb_if.slave  bus
);
    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    logic             r_rd_pend;
    logic             r_rd_tag;

    logic             w_gnt0_raw;
    logic             w_gnt1_raw;
    logic             w_gnt0;
    logic             w_gnt1;
    arb_state_t       w_nxt_state;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_nxt_last;
    logic             w_accept_rd;
    logic             w_rv0;
    logic             w_rv1;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    dmem_arb_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .i_req0      (bus.m0_req),
        .i_req1      (bus.m1_req),
        .i_state     (r_state),
        .i_cnt       (r_cnt),
        .i_last      (r_last),
        .o_gnt0      (w_gnt0_raw),
        .o_gnt1      (w_gnt1_raw),
        .o_nxt_state (w_nxt_state),
        .o_nxt_cnt   (w_nxt_cnt),
        .o_nxt_last  (w_nxt_last)
    );

    // Grants are masked while reset is held so no memory access can slip
    // through from requests that are already high.
    assign w_gnt0      = w_gnt0_raw & reset_n;
    assign w_gnt1      = w_gnt1_raw & reset_n;
    assign w_accept_rd = (w_gnt0 & ~bus.m0_we) | (w_gnt1 & ~bus.m1_we);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ARB_IDLE;
            r_cnt     <= '0;
            r_last    <= M_DBG;
            r_rd_pend <= 1'b0;
            r_rd_tag  <= M_CPU;
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_last    <= w_nxt_last;
            r_rd_pend <= w_accept_rd;
            r_rd_tag  <= w_gnt1 ? M_DBG : M_CPU;
        end
    end

    assign w_rv0 = r_rd_pend & (r_rd_tag == M_CPU);
    assign w_rv1 = r_rd_pend & (r_rd_tag == M_DBG);

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.m0_rvalid = w_rv0;
    assign bus.m1_rvalid = w_rv1;
    assign bus.m0_rdata  = w_rv0 ? bus.mem_rdata : '0;
    assign bus.m1_rdata  = w_rv1 ? bus.mem_rdata : '0;

    // With no grant the address/data lines rest on the m0 values.
    assign w_mem_addr    = w_gnt1 ? bus.m1_addr  : bus.m0_addr;
    assign w_mem_wdata   = w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
    assign bus.mem_en    = w_gnt0 | w_gnt1;
    assign bus.mem_we    = (w_gnt0 & bus.m0_we) | (w_gnt1 & bus.m1_we);
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    assign bus.busy      = (r_state != ARB_IDLE) | r_rd_pend;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic clock = 1'b0;
    logic reset_n;

    dmem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Synchronous memory model: write lands at the edge, read data next cycle.
    logic [DATA_W-1:0] mem [0:1023];
    bit                mem_init = 1'b0;

    function automatic logic [DATA_W-1:0] init_val(input int a);
        if (a == 5) return 32'hAA;
        if (a == 9) return 32'hBB;
        return 32'h100 + a;
    endfunction

    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Expected grant pattern while m0 streams 10 reads and m1 re-requests one
    // beat at a time (drops req for one cycle after each grant).
`ifdef DMEM_ARB_FIXED_PRIO_EN
    bit exp_g0 [13] = '{1,1,1,1,1,1,1,1,1,1,0,0,0};
    bit exp_g1 [13] = '{0,0,0,0,0,0,0,0,0,0,1,0,1};
`else
    bit exp_g0 [13] = '{1,1,1,1,0,1,1,1,1,0,1,1,0};
    bit exp_g1 [13] = '{0,0,0,0,1,0,0,0,0,1,0,0,1};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc0;
        bit  m1r;
        bit  g0s, g1s;
        int  wait1, maxw, ngnt1;

        reset_n       = 1'b0;
        bus.m0_req    = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req    = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.mem_rdata = '0;
        repeat (3) tick();

        // Outputs held quiet during reset even with requests high.
        bus.m0_req = 1'b1; bus.m1_req = 1'b1;
        #1;
        check_val("rst_gnt0",   bus.m0_gnt, 0);
        check_val("rst_gnt1",   bus.m1_gnt, 0);
        check_val("rst_mem_en", bus.mem_en, 0);
        check_val("rst_busy",   bus.busy, 0);
        check_val("rst_rv0",    bus.m0_rvalid, 0);
        check_val("rst_rdata0", bus.m0_rdata, 0);
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        tick();
        reset_n = 1'b1;

        // Test 1: both read after reset; m0 first, m1 next with no bubble.
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 10'd5;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 10'd9;
        @(negedge clock);
        check_val("t1_c0_gnt0",  bus.m0_gnt, 1);
        check_val("t1_c0_gnt1",  bus.m1_gnt, 0);
        check_val("t1_c0_maddr", bus.mem_addr, 5);
        check_val("t1_c0_mwe",   bus.mem_we, 0);
        tick();
        bus.m0_req = 1'b0;
        @(negedge clock);
        check_val("t1_c1_rv0",   bus.m0_rvalid, 1);
        check_val("t1_c1_rd0",   bus.m0_rdata, 32'hAA);
        check_val("t1_c1_gnt1",  bus.m1_gnt, 1);
        check_val("t1_c1_maddr", bus.mem_addr, 9);
        tick();
        bus.m1_req = 1'b0;
        @(negedge clock);
        check_val("t1_c2_rv1",   bus.m1_rvalid, 1);
        check_val("t1_c2_rd1",   bus.m1_rdata, 32'hBB);
        check_val("t1_c2_rv0",   bus.m0_rvalid, 0);
        check_val("t1_c2_rd0",   bus.m0_rdata, 0);
        check_val("t1_c2_busy",  bus.busy, 1);
        tick();
        @(negedge clock);
        check_val("t1_c3_busy",  bus.busy, 0);
        tick();

        // Test 2: m0 streams 10 reads (addr 0..9), m1 keeps coming back.
        acc0 = 0; m1r = 1'b1; wait1 = 0; maxw = 0;
        bus.m1_addr = 10'd20; bus.m1_we = 1'b0; bus.m0_we = 1'b0;
        for (int c = 0; c < 13; c++) begin
            bus.m0_req  = (acc0 < 10);
            bus.m0_addr = 10'(acc0);
            bus.m1_req  = m1r;
            @(negedge clock);
            check_val($sformatf("t2_c%0d_gnt0", c), bus.m0_gnt, exp_g0[c]);
            check_val($sformatf("t2_c%0d_gnt1", c), bus.m1_gnt, exp_g1[c]);
            check_val($sformatf("t2_c%0d_rv0", c), bus.m0_rvalid, (c > 0) ? exp_g0[c-1] : 1'b0);
            check_val($sformatf("t2_c%0d_rv1", c), bus.m1_rvalid, (c > 0) ? exp_g1[c-1] : 1'b0);
            if (c > 0 && exp_g0[c-1])
                check_val($sformatf("t2_c%0d_rd0", c), bus.m0_rdata, init_val(acc0 - 1));
            g0s = bus.m0_gnt;
            g1s = bus.m1_gnt;
            if (bus.m1_req && !g1s) wait1++;
            else                    wait1 = 0;
            if (wait1 > maxw) maxw = wait1;
            if (g0s) acc0++;
            m1r = !g1s;
            tick();
        end
`ifndef DMEM_ARB_FIXED_PRIO_EN
        check_val("t2_m1_maxwait_le4", (maxw <= 4), 1);
`endif
        check_val("t2_m0_count", acc0, 10);
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        tick(); tick();

        // Test 3: m1 writes, m0 reads the same address on the next cycle.
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 10'd3; bus.m1_wdata = 32'h1234;
        @(negedge clock);
        check_val("t3_wr_gnt1",  bus.m1_gnt, 1);
        check_val("t3_wr_mwe",   bus.mem_we, 1);
        check_val("t3_wr_wdata", bus.mem_wdata, 32'h1234);
        tick();
        bus.m1_req = 1'b0;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 10'd3;
        @(negedge clock);
        check_val("t3_rd_gnt0",  bus.m0_gnt, 1);
        check_val("t3_wr_norv1", bus.m1_rvalid, 0);
        tick();
        bus.m0_req = 1'b0;
        @(negedge clock);
        check_val("t3_rv0", bus.m0_rvalid, 1);
        check_val("t3_rd0", bus.m0_rdata, 32'h1234);
        tick(); tick();

        // Test 4: only m1 requests for 20 cycles (writes).
        ngnt1 = 0;
        bus.m1_we = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.m1_req   = 1'b1;
            bus.m1_addr  = 10'(100 + c);
            bus.m1_wdata = 32'(c);
            @(negedge clock);
            if (bus.m1_gnt) ngnt1++;
            if (bus.m0_gnt) check_val("t4_no_gnt0", bus.m0_gnt, 0);
            tick();
        end
        check_val("t4_gnt1_count", ngnt1, 20);
        check_val("t4_cnt_sat",    dut.r_cnt, 4);
        check_val("t4_busy",       bus.busy, 1);
        bus.m1_req = 1'b0; bus.m1_we = 1'b0;
        tick(); tick();

        // Test 5: reset right after an accepted m0 read.
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 10'd5;
        @(negedge clock);
        check_val("t5_gnt0", bus.m0_gnt, 1);
        tick();
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b1;
        reset_n = 1'b0;
        #1;
        check_val("t5_rst_rv0",    bus.m0_rvalid, 0);
        check_val("t5_rst_rd0",    bus.m0_rdata, 0);
        check_val("t5_rst_busy",   bus.busy, 0);
        check_val("t5_rst_gnt1",   bus.m1_gnt, 0);
        check_val("t5_rst_mem_en", bus.mem_en, 0);
        tick();
        reset_n = 1'b1;
        bus.m0_req = 1'b1; bus.m0_addr = 10'd9;
        @(negedge clock);
        check_val("t5_post_gnt0", bus.m0_gnt, 1);
        check_val("t5_post_gnt1", bus.m1_gnt, 0);
        tick();
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
